// File: rtl/riscv32s_io_fabric.sv
// riscv32s data-side decoder: steers core loads/stores to RAM or the I/O window.
// I/O window holds a byte stream FIFO, STATUS/CONTROL and optional CYCLES (RISCV32S_CYCLE_COUNTER_EN).
module riscv32s_io_fabric #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] IO_BASE   = 32'hFFFF_FF00,
  parameter int              FIFO_DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] ramaddress,
  input  logic [WIDTH-1:0] writeramdata,
  input  logic             writeram,
  output logic [WIDTH-1:0] readramdata,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_enw,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [7:0]       stream_data,
  output logic             stream_valid,
  input  logic             stream_ready,
  output logic             halted
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic       io_hit;
  logic [7:0] off;
  logic       push_req;
  logic       ctrl_wr;
  logic       full;
  logic       empty;
  logic       push_ok;
  logic       drop;
  logic       pop;

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          halted_q, halted_d;
  logic [WIDTH-1:0] cyc_rd;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] io_rd;

  assign io_hit      = ramaddress[WIDTH-1:8] == IO_BASE[WIDTH-1:8];
  assign off         = ramaddress[7:0];
  assign mem_address = ramaddress;
  assign mem_wdata   = writeramdata;
  assign mem_enw     = writeram & ~io_hit;

  assign push_req = writeram & io_hit & (off == 8'h00);
  assign ctrl_wr  = writeram & io_hit & (off == 8'h08);
  assign full     = count_q == CW'(FIFO_DEPTH);
  assign empty    = count_q == '0;
  assign push_ok  = push_req & ~full;
  assign drop     = push_req & full;
  assign pop      = stream_valid & stream_ready;

  assign stream_valid = ~empty;
  assign stream_data  = fifo_q[rd_ptr_q];
  assign halted       = halted_q;

  // FIFO, overflow and halt next-state
  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    halted_d = halted_q;
    if (push_ok) begin
      fifo_d[wr_ptr_q] = writeramdata[7:0];
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (ctrl_wr & writeramdata[0]) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
    if (ctrl_wr & writeramdata[1]) begin
      halted_d = 1'b1;
    end
  end

  // state registers, storage cleared so stream_data is never X
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      halted_q <= halted_d;
    end
  end

`ifdef RISCV32S_CYCLE_COUNTER_EN
  logic [WIDTH-1:0] cyc_q, cyc_d;

  // free-running cycle counter, frozen once halted
  always_comb begin
    cyc_d = cyc_q;
    if (!halted_q) begin
      cyc_d = cyc_q + WIDTH'(1);
    end
  end

  // cycle counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cyc_rd = cyc_q;
`else
  assign cyc_rd = '0;
`endif

  // load data: RAM or the selected I/O register
  always_comb begin
    status       = '0;
    status[0]    = full;
    status[1]    = empty;
    status[2]    = ovf_q;
    status[3]    = halted_q;
    status[15:8] = 8'(count_q);
    io_rd        = '0;
    case (off)
      8'h04:   io_rd = status;
      8'h0C:   io_rd = cyc_rd;
      default: io_rd = '0;
    endcase
    readramdata = io_hit ? io_rd : mem_rdata;
  end

endmodule

// File: tb/tb_riscv32s_io_fabric.sv
// Bench for riscv32s_io_fabric: directed table, hand sequences, random vs model.
// Build with RISCV32S_CYCLE_COUNTER_EN to cover the CYCLES register.
module tb_riscv32s_io_fabric;

  localparam logic [31:0] IOB = 32'hFFFF_FF00;
  localparam int DEPTH = 16;

  logic        clock;
  logic        reset;
  logic [31:0] ramaddress;
  logic [31:0] writeramdata;
  logic        writeram;
  logic [31:0] readramdata;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_enw;
  logic [31:0] mem_rdata;
  logic [7:0]  stream_data;
  logic        stream_valid;
  logic        stream_ready;
  logic        halted;

  riscv32s_io_fabric dut (
    .clock        (clock),
    .reset        (reset),
    .ramaddress   (ramaddress),
    .writeramdata (writeramdata),
    .writeram     (writeram),
    .readramdata  (readramdata),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_enw      (mem_enw),
    .mem_rdata    (mem_rdata),
    .stream_data  (stream_data),
    .stream_valid (stream_valid),
    .stream_ready (stream_ready),
    .halted       (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] bram [256];
  assign mem_rdata = bram[mem_address[9:2]];
  always @(posedge clock) begin
    if (mem_enw) bram[mem_address[9:2]] <= mem_wdata;
  end

  // reference model state
  logic [7:0]  q[$];
  bit          m_ovf;
  bit          m_hlt;
  logic [31:0] m_cyc;
  logic [31:0] ref_ram [256];

  int nvec;
  int nmis;

  logic [31:0] s_rd;
  logic        s_valid;
  logic        s_enw;
  logic [7:0]  s_data;
  logic        s_halt;

  function automatic bit is_hit(input logic [31:0] a);
    return a[31:8] == IOB[31:8];
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] v;
    v = 32'(q.size()) << 8;
    if (q.size() == DEPTH) v = v + 1;
    if (q.size() == 0) v = v + 2;
    if (m_ovf) v = v + 4;
    if (m_hlt) v = v + 8;
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (!is_hit(a)) return ref_ram[a[9:2]];
    if (a[7:0] == 8'h04) return m_status();
`ifdef RISCV32S_CYCLE_COUNTER_EN
    if (a[7:0] == 8'h0C) return m_cyc;
`endif
    return 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_step(input logic [31:0] a, input logic [31:0] wd,
                            input logic wr, input logic rdy, input logic rst);
    bit full0;
    bit hlt0;
    if (wr && !is_hit(a)) ref_ram[a[9:2]] = wd;
    if (rst) begin
      q.delete();
      m_ovf = 0;
      m_hlt = 0;
      m_cyc = 0;
      return;
    end
    full0 = q.size() == DEPTH;
    hlt0  = m_hlt;
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (wr && is_hit(a) && a[7:0] == 8'h08) begin
      if (wd[0]) m_ovf = 0;
      if (wd[1]) m_hlt = 1;
    end
    if (wr && is_hit(a) && a[7:0] == 8'h00) begin
      if (full0) m_ovf = 1;
      else q.push_back(wd[7:0]);
    end
    if (!hlt0) m_cyc = m_cyc + 1;
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] wd,
                       input logic wr, input logic rdy, input logic rst);
    ramaddress   = a;
    writeramdata = wd;
    writeram     = wr;
    stream_ready = rdy;
    reset        = rst;
    @(negedge clock);
    s_rd    = readramdata;
    s_valid = stream_valid;
    s_enw   = mem_enw;
    s_data  = stream_data;
    s_halt  = halted;
    chk("readramdata", readramdata, exp_rd(a));
    chk("mem_enw", 32'(mem_enw), 32'(wr && !is_hit(a)));
    chk("mem_address", mem_address, a);
    chk("mem_wdata", mem_wdata, wd);
    chk("stream_valid", 32'(stream_valid), 32'(q.size() != 0));
    chk("halted", 32'(halted), 32'(m_hlt));
    if (q.size() != 0) chk("stream_data", 32'(stream_data), 32'(q[0]));
    @(posedge clock);
    model_step(a, wd, wr, rdy, rst);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        wr;
    logic        rdy;
    logic [31:0] e_rd;
    logic        e_valid;
    logic        e_enw;
    logic [7:0]  e_data;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [31:0] v0;
    logic [31:0] a;
    logic [31:0] wd;
    nvec = 0;
    nmis = 0;
    for (int i = 0; i < 256; i++) begin
      bram[i]    = '0;
      ref_ram[i] = '0;
    end
    tbl[0] = '{32'h40,     32'h1234, 1, 0, 32'h0,    0, 1, 8'h00};
    tbl[1] = '{32'h40,     32'h0,    0, 0, 32'h1234, 0, 0, 8'h00};
    tbl[2] = '{IOB,        32'hA5,   1, 0, 32'h0,    0, 0, 8'h00};
    tbl[3] = '{IOB,        32'h3C,   1, 0, 32'h0,    1, 0, 8'hA5};
    tbl[4] = '{IOB + 4,    32'h0,    0, 0, 32'h0200, 1, 0, 8'hA5};
    tbl[5] = '{IOB + 4,    32'h0,    0, 1, 32'h0200, 1, 0, 8'hA5};
    tbl[6] = '{IOB + 4,    32'h0,    0, 1, 32'h0100, 1, 0, 8'h3C};
    tbl[7] = '{IOB + 4,    32'h0,    0, 1, 32'h0002, 0, 0, 8'h00};

    ramaddress   = '0;
    writeramdata = '0;
    writeram     = 1'b0;
    stream_ready = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clock);
    model_step('0, '0, 0, 0, 1);
    #1;

    apply(IOB + 4, 0, 0, 0, 0);
    chk("reset_status", s_rd, 32'h0000_0002);
    chk("reset_valid", 32'(s_valid), 32'h0);

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].addr, tbl[i].wd, tbl[i].wr, tbl[i].rdy, 0);
      chk($sformatf("tbl%0d_rd", i), s_rd, tbl[i].e_rd);
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_enw", i), 32'(s_enw), 32'(tbl[i].e_enw));
      if (tbl[i].e_valid)
        chk($sformatf("tbl%0d_data", i), 32'(s_data), 32'(tbl[i].e_data));
    end

    for (int i = 0; i < 17; i++) begin
      apply(IOB, 32'h10 + i, 1, 0, 0);
      chk("push_enw", 32'(s_enw), 32'h0);
    end
    apply(IOB + 4, 0, 0, 0, 0);
    chk("ovf_status", s_rd, 32'h0000_1005);
    apply(IOB + 8, 1, 1, 0, 0);
    chk("ctrl_enw", 32'(s_enw), 32'h0);
    apply(IOB + 4, 0, 0, 0, 0);
    chk("clr_status", s_rd, 32'h0000_1001);

    apply(IOB, 32'hEE, 1, 1, 0);
    apply(IOB + 4, 0, 0, 0, 0);
    chk("full_pushpop_status", s_rd, 32'h0000_0F04);
    chk("full_pushpop_head", 32'(s_data), 32'h11);

    repeat (10) apply(IOB + 4, 0, 0, 1, 0);
    apply(IOB + 8, 2, 1, 0, 0);
    apply(IOB + 4, 0, 0, 0, 0);
    chk("halt_flag", 32'(s_halt), 32'h1);
    chk("halt_status", s_rd, 32'h0000_050C);
    apply(IOB, 32'h77, 1, 1, 1);
    apply(IOB + 4, 0, 0, 0, 0);
    chk("midreset_status", s_rd, 32'h0000_0002);
    chk("midreset_valid", 32'(s_valid), 32'h0);
    chk("midreset_halted", 32'(s_halt), 32'h0);

`ifdef RISCV32S_CYCLE_COUNTER_EN
    apply(IOB + 12, 0, 0, 0, 0);
    v0 = s_rd;
    repeat (9) apply(32'h80, 0, 0, 0, 0);
    apply(IOB + 12, 0, 0, 0, 0);
    chk("cycles_delta", s_rd - v0, 32'd10);
    apply(IOB + 8, 2, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(IOB + 12, 0, 0, 0, 0);
      chk("cycles_frozen", s_rd, v0 + 32'd12);
      chk("cycles_halted", 32'(s_halt), 32'h1);
    end
`else
    v0 = '0;
    apply(IOB + 12, 0, 0, 0, 0);
    chk("cycles_absent", s_rd, v0);
`endif

    apply(IOB, 0, 0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      wd = $urandom;
      case ($urandom_range(0, 5))
        0: a = $urandom & 32'h0000_03FC;
        1: a = IOB;
        2: a = IOB + 4;
        3: begin
          a = IOB + 8;
          if ($urandom_range(0, 15) != 0) wd[1] = 1'b0;
        end
        4: a = IOB + 12;
        default: a = IOB + 32'($urandom_range(0, 255));
      endcase
      apply(a, wd, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 79) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
